ring_decoder: RTL



---
 rtl/ring_decoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ring_decoder.sv
// Decodes a one-hot ring pattern to a binary index and monitors rotation lock.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; ring_valid=0 freezes all state, and a pending err pulse still clears.
module ring_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     ring_valid,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     err,
    output logic [ERR_W-1:0]         err_count
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] expected;

    logic             onehot;
    logic [IDX_W-1:0] enc;
    logic [WIDTH-1:0] rot_in;
    logic             match;
    logic [CNT_W-1:0] count_nxt;
    logic [ERR_W-1:0] err_count_inc;

    // Sample classification: one-hot test, bit-position encode, next expected pattern.
    always_comb begin
        onehot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
        enc    = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (ring_in[k]) begin
                enc = IDX_W'(k);
            end
        end
        // The set bit walks from MSB toward LSB and wraps back to the MSB.
        rot_in        = {ring_in[0], ring_in[WIDTH-1:1]};
        // In VERIFY/LOCKED expected is always one-hot, so a match implies a one-hot sample.
        match         = (ring_in == expected);
        count_nxt     = count + CNT_ONE;
        err_count_inc = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);
    end

    // Lock FSM with registered decode, lock, error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= HUNT;
            count     <= '0;
            expected  <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            // err is a single-cycle pulse regardless of ring_valid.
            err <= 1'b0;
            if (ring_valid) begin
                idx_valid <= onehot;
                if (onehot) begin
                    idx <= enc;
                end
                case (state)
                    HUNT: begin
                        if (onehot) begin
                            state    <= VERIFY;
                            count    <= CNT_ONE;
                            expected <= rot_in;
                        end
                    end
                    VERIFY: begin
                        if (match) begin
                            count    <= count_nxt;
                            expected <= rot_in;
                            if (count_nxt == CNT_LOCK) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (onehot) begin
                            count    <= CNT_ONE;
                            expected <= rot_in;
                        end else begin
                            state <= HUNT;
                            count <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            expected <= rot_in;
                        end else begin
                            locked    <= 1'b0;
                            err       <= 1'b1;
                            err_count <= err_count_inc;
                            if (onehot) begin
                                state    <= VERIFY;
                                count    <= CNT_ONE;
                                expected <= rot_in;
                            end else begin
                                state <= HUNT;
                                count <= '0;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        count  <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
